// File: rtl/fp8_e4m3_accumulator.sv
// Exact fixed-point reduction of an E4M3 burst with a single round-to-nearest-even
// conversion back to E4M3 once the last operand has been absorbed.
module fp8_e4m3_accumulator #(
    parameter int ACC_W = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat
);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_CONV,
        ST_OUT
    } state_t;

    localparam int NW = ACC_W - 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic                    nan_seen;
    logic                    all_negzero;

    logic                    in_hs;
    logic                    out_hs;

    // operand decode
    logic [3:0]              in_exp;
    logic [2:0]              in_mant;
    logic                    in_nan;
    logic [17:0]             in_mag;
    logic signed [ACC_W:0]   in_val;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W-1:0] acc_clamped;

    // conversion
    logic                    acc_neg;
    logic [ACC_W-1:0]        acc_abs;
    logic [7:0]              lead;
    logic [7:0]              norm_sh;
    logic [NW-1:0]           norm;
    logic [2:0]              mant_trunc;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [3:0]              mant_rnd;
    logic [2:0]              mant_fin;
    logic [7:0]              exp_rnd;
    logic                    conv_sat;
    logic [7:0]              conv_data;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        in_exp  = in_data[6:3];
        in_mant = in_data[2:0];
        in_nan  = (in_data[6:0] == 7'h7F);
        if (in_exp == 4'd0) begin
            in_mag = {15'd0, in_mant};
        end else begin
            in_mag = {14'd0, 1'b1, in_mant} << (in_exp - 4'd1);
        end
        if (in_data[7]) begin
            in_val = -$signed({{(ACC_W-17){1'b0}}, in_mag});
        end else begin
            in_val = $signed({{(ACC_W-17){1'b0}}, in_mag});
        end
    end

    // One guard bit of headroom detects signed overflow, which then clamps.
    always_comb begin
        acc_sum = {acc[ACC_W-1], acc} + in_val;
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
            acc_clamped = acc_sum[ACC_W] ? -ACC_MAX : ACC_MAX;
        end else begin
            acc_clamped = acc_sum[ACC_W-1:0];
        end
    end

    always_comb begin
        acc_neg = acc[ACC_W-1];
        acc_abs = acc_neg ? -acc : acc;
        lead    = '0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            if (acc_abs[i]) begin
                lead = 8'(i);
            end
        end
        // Left-justify so the leading one falls off the top; mantissa, guard and
        // sticky then sit at fixed positions independent of the exponent.
        norm_sh    = 8'(ACC_W - 1) - lead;
        norm       = NW'(acc_abs << norm_sh);
        mant_trunc = norm[NW-1 -: 3];
        guard      = norm[NW-4];
        sticky     = |norm[NW-5:0];
        round_up   = guard && (sticky || mant_trunc[0]);
        mant_rnd   = {1'b0, mant_trunc} + {3'd0, round_up};
        exp_rnd    = lead - 8'd2 + {7'd0, mant_rnd[3]};
        mant_fin   = mant_rnd[3] ? 3'd0 : mant_rnd[2:0];

        conv_sat  = 1'b0;
        conv_data = '0;
        if (nan_seen) begin
            conv_data = 8'h7F;
        end else if (acc_abs == '0) begin
            conv_data = all_negzero ? 8'h80 : 8'h00;
        end else if (acc_abs < ACC_W'(8)) begin
            conv_data = {acc_neg, 4'd0, acc_abs[2:0]};
        end else if ((exp_rnd > 8'd15) || ((exp_rnd == 8'd15) && (mant_fin == 3'd7))) begin
            conv_data = {acc_neg, 7'h7E};
            conv_sat  = 1'b1;
        end else begin
            conv_data = {acc_neg, exp_rnd[3:0], mant_fin};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (in_hs && in_last) state_nxt = ST_CONV;
            ST_CONV: state_nxt = ST_OUT;
            ST_OUT:  if (out_hs) state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // out_valid is a flop fed by the OUT state, so it rises one edge after OUT
    // is entered; out_data/out_sat are already stable by then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            nan_seen    <= 1'b0;
            all_negzero <= 1'b1;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sat     <= 1'b0;
        end else begin
            in_ready <= (state_nxt == ST_ACC);
            if (in_hs) begin
                acc         <= acc_clamped;
                nan_seen    <= nan_seen || in_nan;
                all_negzero <= all_negzero && (in_data == 8'h80);
            end
            if (state == ST_CONV) begin
                out_data <= conv_data;
                out_sat  <= conv_sat;
            end
            if (state == ST_OUT) begin
                if (out_hs) begin
                    out_valid   <= 1'b0;
                    acc         <= '0;
                    nan_seen    <= 1'b0;
                    all_negzero <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp8_e4m3_accumulator.sv
// Self-checking bench: directed spec bursts plus randomized bursts against a
// nearest-representable-value reference model.
module tb_fp8_e4m3_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;

    int errors = 0;
    int checks = 0;

    logic [7:0] burst_q[$];

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp_d;
        logic       exp_s;
    } vec_t;

    always #5 clk = ~clk;

    fp8_e4m3_accumulator #(.ACC_W(28)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Real value of a code in units of 2^-9.
    function automatic longint code_mag(input int c);
        int e;
        int mn;
        e  = (c >> 3) & 15;
        mn = c & 7;
        if (e == 0) return longint'(mn);
        return longint'(8 + mn) * (longint'(1) << (e - 1));
    endfunction

    task automatic model(output logic [7:0] d, output logic s);
        bit     nan;
        bit     negz;
        longint sum;
        longint m;
        longint dd;
        longint bestd;
        int     best;
        logic [7:0] bb;
        nan  = 0;
        negz = 1;
        sum  = 0;
        foreach (burst_q[i]) begin
            bb = burst_q[i];
            if (bb[6:0] == 7'h7F) nan = 1;
            if (bb != 8'h80) negz = 0;
            sum += bb[7] ? -code_mag(int'(bb[6:0])) : code_mag(int'(bb[6:0]));
        end
        s = 1'b0;
        if (nan) begin
            d = 8'h7F;
        end else if (sum == 0) begin
            d = negz ? 8'h80 : 8'h00;
        end else begin
            m = (sum < 0) ? -sum : sum;
            if (m > 64'd237568) begin
                d = {sum < 0, 7'h7E};
                s = 1'b1;
            end else begin
                best  = 0;
                bestd = 64'h7FFF_FFFF_FFFF;
                for (int c = 0; c < 127; c++) begin
                    dd = code_mag(c) - m;
                    if (dd < 0) dd = -dd;
                    if (dd < bestd || (dd == bestd && (c % 2) == 0)) begin
                        best  = c;
                        bestd = dd;
                    end
                end
                d = {sum < 0, 7'(best)};
            end
        end
    endtask

    task automatic send_burst(input int gap_max, output bit to);
        int n;
        to = 0;
        for (int i = 0; i < burst_q.size(); i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = burst_q[i];
            in_last  = (i == burst_q.size() - 1);
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready) begin
                to = 1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic take_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_sat} !== 11'd0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%h sat=%b expected all zero",
                     in_ready, out_valid, out_data, out_sat);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed;
        vec_t v[15];
        bit   to;
        int   cyc;
        v[0]  = '{2, 8'h38, 8'h38, 8'h00, 8'h40, 1'b0};
        v[1]  = '{3, 8'h38, 8'h38, 8'h38, 8'h44, 1'b0};
        v[2]  = '{2, 8'h38, 8'h1C, 8'h00, 8'h39, 1'b0};
        v[3]  = '{2, 8'h38, 8'h18, 8'h00, 8'h38, 1'b0};
        v[4]  = '{2, 8'h39, 8'h18, 8'h00, 8'h3A, 1'b0};
        v[5]  = '{2, 8'h38, 8'hB8, 8'h00, 8'h00, 1'b0};
        v[6]  = '{2, 8'h80, 8'h80, 8'h00, 8'h80, 1'b0};
        v[7]  = '{2, 8'h01, 8'h01, 8'h00, 8'h02, 1'b0};
        v[8]  = '{2, 8'h07, 8'h01, 8'h00, 8'h08, 1'b0};
        v[9]  = '{2, 8'h7E, 8'h7E, 8'h00, 8'h7E, 1'b1};
        v[10] = '{2, 8'hFE, 8'h38, 8'h00, 8'hFE, 1'b0};
        v[11] = '{3, 8'h38, 8'h7F, 8'hB8, 8'h7F, 1'b0};
        v[12] = '{3, 8'h7E, 8'h01, 8'hFE, 8'h01, 1'b0};
        v[13] = '{1, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0};
        v[14] = '{1, 8'hFF, 8'h00, 8'h00, 8'h7F, 1'b0};
        for (int k = 0; k < 15; k++) begin
            burst_q = {};
            burst_q.push_back(v[k].b0);
            if (v[k].n > 1) burst_q.push_back(v[k].b1);
            if (v[k].n > 2) burst_q.push_back(v[k].b2);
            send_burst(0, to);
            wait_out(cyc);
            checks++;
            if (to || cyc != 2) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d edges (stall=%0b) expected 2", k, cyc, to);
            end
            checks++;
            if (out_data !== v[k].exp_d || out_sat !== v[k].exp_s) begin
                errors++;
                $display("FAIL directed[%0d]: got data=%h sat=%b expected data=%h sat=%b",
                         k, out_data, out_sat, v[k].exp_d, v[k].exp_s);
            end
            take_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL release[%0d]: got vld=%b rdy=%b expected vld=0 rdy=1",
                         k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        bit         to;
        int         cyc;
        logic [7:0] ed;
        logic       es;
        burst_q = '{8'h38, 8'h39, 8'hB0};
        model(ed, es);
        send_burst(1, to);
        wait_out(cyc);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ed || out_sat !== es) begin
                errors++;
                $display("FAIL backpressure[%0d]: got vld=%b rdy=%b data=%h sat=%b expected vld=1 rdy=0 data=%h sat=%b",
                         k, out_valid, in_ready, out_data, out_sat, ed, es);
            end
            @(posedge clk); #1;
        end
        take_out();
    endtask

    task automatic test_random;
        bit         to;
        int         cyc;
        int         len;
        logic [7:0] ed;
        logic       es;
        logic [7:0] b;
        for (int k = 0; k < 60; k++) begin
            burst_q = {};
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                if ((k % 10) == 3) b = 8'h80;
                else if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 15)) | (8'($urandom_range(0, 1)) << 7);
                else b = 8'($urandom_range(0, 255));
                burst_q.push_back(b);
            end
            model(ed, es);
            send_burst(2, to);
            wait_out(cyc);
            checks++;
            if (to || !out_valid || out_data !== ed || out_sat !== es) begin
                errors++;
                $display("FAIL random[%0d]: got vld=%b data=%h sat=%b expected data=%h sat=%b",
                         k, out_valid, out_data, out_sat, ed, es);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            take_out();
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int cyc;
        int n;
        in_valid = 1'b1;
        in_data  = 8'h38;
        in_last  = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_sat} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_burst: got rdy=%b vld=%b data=%h sat=%b expected all zero",
                     in_ready, out_valid, out_data, out_sat);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        burst_q = '{8'h40, 8'h40};
        send_burst(0, to);
        wait_out(cyc);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_sat} !== 10'd0) begin
            errors++;
            $display("FAIL reset_in_out: got vld=%b data=%h sat=%b expected all zero",
                     out_valid, out_data, out_sat);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        burst_q = '{8'h40};
        send_burst(0, to);
        wait_out(cyc);
        checks++;
        if (to || !out_valid || out_data !== 8'h40 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_burst: got vld=%b data=%h sat=%b expected data=40 sat=0",
                     out_valid, out_data, out_sat);
        end
        take_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
